// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM states shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_STORE,
    S_RESP
  } lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] rep;
  // pick the addressed lane, extend it, and splice store data into the old word
  always_comb begin
    b = rd_word[{lane, 3'b000} +: 8];
    h = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'h0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'h0, h} : rd_word;
    mask = funct3[1:0] == 2'b00 ? 32'hFF << {lane, 3'b000} :
           funct3[1:0] == 2'b01 ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
    rep  = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
           funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    store_data = (base_word & ~mask) | (rep & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto word memory, sub-word stores as read-modify-write
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_done,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  lsu_state_t  state;
  logic        err_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_r;
  logic [31:0] rdata_r;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic        legal;
  logic        misaligned;
  logic        bad;

  lsu_lane_align u_align (
    .funct3     (f3_r),
    .lane       (addr_r[1:0]),
    .rd_word    (mem_dout),
    .base_word  (merge_r),
    .wdata      (wdata_r),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // classify the incoming request as illegal or misaligned before accepting it
  always_comb begin
    legal = req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
            (!req_write && (req_funct3 == F3_BU || req_funct3 == F3_HU));
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    bad = !legal || misaligned;
  end

  // request capture, access sequencing and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      err_r   <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      merge_r <= 32'h0;
      rdata_r <= 32'h0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          err_r   <= bad;
          f3_r    <= req_funct3;
          addr_r  <= req_addr;
          wdata_r <= req_wdata;
          state   <= bad ? S_RESP : !req_write ? S_LOAD : req_funct3 == F3_W ? S_STORE : S_RMW_READ;
        end
        S_LOAD: begin
          rdata_r <= load_data;
          state   <= S_RESP;
        end
        S_RMW_READ: begin
          merge_r <= mem_dout;
          state   <= S_STORE;
        end
        S_STORE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr   = {addr_r[31:2], 2'b00};
  assign mem_din    = store_data;
  assign mem_read   = state == S_LOAD || state == S_RMW_READ;
  assign mem_write  = state == S_STORE && !reset;
  assign resp_done  = state == S_RESP;
  assign resp_err   = state == S_RESP && err_r;
  assign resp_rdata = rdata_r;
endmodule
